alu_mp_sequencer: RTL and testbench

Multi-precision arithmetic sequencer in front of the 8-bit ALU.
- Accepts one ADD or SUB request on operands up to MAX_BYTES bytes wide.
- Issues byte-serial ALU operations, least significant byte first.
- Propagates carry/borrow with explicit INC/DEC fix-up operations, then returns the wide result and aggregate flags.
- Sits between the control unit and the ALU; it is the ALU's only driver while busy.

---
 rtl/alu_mp_sequencer_pkg.sv | 23 ++
 rtl/alu_mp_sequencer_if.sv | 52 +++++
 rtl/alu_mp_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_alu_mp_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_mp_sequencer_pkg.sv
// alu_mp_sequencer_pkg
//   Shared constants for the multi-precision ALU sequencer:
//   - ALUOP_* : 5-bit opcode encodings understood by the 8-bit ALU.
//   - ALUSEQ_ST_* : sequencer FSM state encodings.
package alu_mp_sequencer_pkg;

  typedef logic [4:0] aluop_t;

  // PD1 passes Data1 through without touching flags; it is the idle opcode.
  localparam aluop_t ALUOP_PD1 = 5'h00;
  localparam aluop_t ALUOP_ADD = 5'h01;
  localparam aluop_t ALUOP_SUB = 5'h02;
  localparam aluop_t ALUOP_INC = 5'h03;
  localparam aluop_t ALUOP_DEC = 5'h04;

  localparam logic [2:0] ALUSEQ_ST_IDLE = 3'd0;
  localparam logic [2:0] ALUSEQ_ST_OP   = 3'd1;
  localparam logic [2:0] ALUSEQ_ST_OPW  = 3'd2;
  localparam logic [2:0] ALUSEQ_ST_FIX  = 3'd3;
  localparam logic [2:0] ALUSEQ_ST_FIXW = 3'd4;
  localparam logic [2:0] ALUSEQ_ST_DONE = 3'd5;

endpackage

// File: rtl/alu_mp_sequencer_if.sv
// alu_mp_sequencer_if
//   Bundles the request/response signals of the sequencer and its private
//   link to the 8-bit ALU.
//   Modports:
//     slave  : the sequencer (receives requests, drives the ALU).
//     master : control unit + ALU side (issues requests, returns ALU results).
//   Optional: `define ALUSEQ_OVF_EN adds the o_OF overflow flag.
interface alu_mp_sequencer_if #(
  parameter int MAX_BYTES = 4,
  parameter int LW        = 3
);
  localparam int W = 8 * MAX_BYTES;

  logic          i_Start;
  logic          i_Sub;
  logic [LW-1:0] i_Len;
  logic [W-1:0]  i_A;
  logic [W-1:0]  i_B;
  logic          o_Busy;
  logic          o_Done;
  logic [W-1:0]  o_Result;
  logic          o_C;
  logic          o_Z;
  logic          o_S;
`ifdef ALUSEQ_OVF_EN
  logic          o_OF;
`endif
  logic [4:0]    o_ALUOp;
  logic [7:0]    o_ALUData1;
  logic [7:0]    o_ALUData2;
  logic [7:0]    i_ALUResult;
  logic          i_ALUC;

  modport slave (
    input  i_Start, i_Sub, i_Len, i_A, i_B, i_ALUResult, i_ALUC,
    output o_Busy, o_Done, o_Result, o_C, o_Z, o_S,
`ifdef ALUSEQ_OVF_EN
    output o_OF,
`endif
    output o_ALUOp, o_ALUData1, o_ALUData2
  );

  modport master (
    output i_Start, i_Sub, i_Len, i_A, i_B, i_ALUResult, i_ALUC,
    input  o_Busy, o_Done, o_Result, o_C, o_Z, o_S,
`ifdef ALUSEQ_OVF_EN
    input  o_OF,
`endif
    input  o_ALUOp, o_ALUData1, o_ALUData2
  );

endinterface

// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer
//   Multi-precision ADD/SUB sequencer in front of the 8-bit ALU. A request of
//   up to MAX_BYTES bytes is run byte-serially, LSB first; carry/borrow from
//   the previous byte is folded in with a separate INC/DEC fix-up op. Every
//   ALU op takes an issue cycle (outputs registered) and a capture cycle.
//   Ports:
//     i_CLK  : clock, all state changes on posedge
//     i_RST  : asynchronous active-high reset
//     bus    : alu_mp_sequencer_if.slave
//              request  : i_Start, i_Sub, i_Len, i_A, i_B
//              response : o_Busy, o_Done, o_Result, o_C, o_Z, o_S [, o_OF]
//              ALU link : o_ALUOp, o_ALUData1, o_ALUData2, i_ALUResult, i_ALUC
//   Optional: `define ALUSEQ_OVF_EN adds the signed-overflow output o_OF.
module alu_mp_sequencer
  import alu_mp_sequencer_pkg::*;
#(
  parameter int MAX_BYTES = 4,
  parameter int LW        = 3
) (
  input logic               i_CLK,
  input logic               i_RST,
  alu_mp_sequencer_if.slave bus
);

  localparam int W = 8 * MAX_BYTES;

  function automatic logic [7:0] get_byte(input logic [W-1:0] w, input logic [LW-1:0] idx);
    return w[8*int'(idx) +: 8];
  endfunction

  function automatic logic [W-1:0] put_byte(input logic [W-1:0] w, input logic [LW-1:0] idx,
                                            input logic [7:0] b);
    logic [W-1:0] r;
    r = w;
    r[8*int'(idx) +: 8] = b;
    return r;
  endfunction

  // Zero or oversize lengths run the full width.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    if (len == '0 || int'(len) > MAX_BYTES) return LW'(MAX_BYTES);
    return len;
  endfunction

  // Control / output state (reset)
  logic [2:0]    state_q, state_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic          sub_q, sub_d;
  logic          cy_q, cy_d;
  logic          zacc_q, zacc_d;
  aluop_t        aluop_q, aluop_d;
  logic [7:0]    d1_q, d1_d;
  logic [7:0]    d2_q, d2_d;
  logic          done_q, done_d;
  logic [W-1:0]  result_q, result_d;
  logic          c_q, c_d;
  logic          z_q, z_d;
  logic          s_q, s_d;
`ifdef ALUSEQ_OVF_EN
  logic          of_q, of_d;
  logic [7:0]    top_a, top_b;
`endif

  // Operand / working data (no reset; always reloaded on start)
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [7:0]    r_q, r_d;
  logic          c1_q, c1_d;

  logic          store_en;
  logic          last;
  logic [7:0]    top_r;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    sub_d    = sub_q;
    cy_d     = cy_q;
    zacc_d   = zacc_q;
    aluop_d  = aluop_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    done_d   = 1'b0;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    s_d      = s_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    r_d      = r_q;
    c1_d     = c1_q;
    store_en = 1'b0;
    last     = (idx_q == len_q - LW'(1));
    // In DONE idx_q still points at the most significant processed byte.
    top_r    = get_byte(acc_q, idx_q);
`ifdef ALUSEQ_OVF_EN
    of_d     = of_q;
    top_a    = get_byte(a_q, idx_q);
    top_b    = get_byte(b_q, idx_q);
`endif

    case (state_q)
      ALUSEQ_ST_IDLE: begin
        aluop_d = ALUOP_PD1;
        if (bus.i_Start) begin
          a_d     = bus.i_A;
          b_d     = bus.i_B;
          sub_d   = bus.i_Sub;
          len_d   = clamp_len(bus.i_Len);
          idx_d   = '0;
          cy_d    = 1'b0;
          zacc_d  = 1'b1;
          acc_d   = '0;
          state_d = ALUSEQ_ST_OP;
        end
      end
      ALUSEQ_ST_OP: begin
        aluop_d = sub_q ? ALUOP_SUB : ALUOP_ADD;
        d1_d    = get_byte(a_q, idx_q);
        d2_d    = get_byte(b_q, idx_q);
        state_d = ALUSEQ_ST_OPW;
      end
      ALUSEQ_ST_OPW: begin
        aluop_d = ALUOP_PD1;
        r_d     = bus.i_ALUResult;
        c1_d    = bus.i_ALUC;
        if (cy_q) begin
          state_d = ALUSEQ_ST_FIX;
        end else begin
          store_en = 1'b1;
          cy_d     = bus.i_ALUC;
        end
      end
      ALUSEQ_ST_FIX: begin
        aluop_d = sub_q ? ALUOP_DEC : ALUOP_INC;
        d1_d    = r_q;
        d2_d    = 8'h00;
        state_d = ALUSEQ_ST_FIXW;
      end
      ALUSEQ_ST_FIXW: begin
        aluop_d  = ALUOP_PD1;
        store_en = 1'b1;
        // The byte op and its fix-up can never both carry, so OR is exact.
        cy_d     = c1_q | bus.i_ALUC;
      end
      ALUSEQ_ST_DONE: begin
        done_d   = 1'b1;
        result_d = acc_q;
        c_d      = cy_q;
        z_d      = zacc_q;
        s_d      = top_r[7];
`ifdef ALUSEQ_OVF_EN
        if (sub_q) of_d = (top_a[7] != top_b[7]) && (top_r[7] != top_a[7]);
        else       of_d = (top_a[7] == top_b[7]) && (top_r[7] != top_a[7]);
`endif
        state_d  = ALUSEQ_ST_IDLE;
      end
      default: state_d = ALUSEQ_ST_IDLE;
    endcase

    // Byte commit and index advance, folded into the capture transition.
    if (store_en) begin
      acc_d  = put_byte(acc_q, idx_q, bus.i_ALUResult);
      zacc_d = zacc_q & (bus.i_ALUResult == 8'h00);
      if (last) begin
        state_d = ALUSEQ_ST_DONE;
      end else begin
        idx_d   = idx_q + LW'(1);
        state_d = ALUSEQ_ST_OP;
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q  <= ALUSEQ_ST_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      sub_q    <= 1'b0;
      cy_q     <= 1'b0;
      zacc_q   <= 1'b0;
      aluop_q  <= ALUOP_PD1;
      d1_q     <= 8'h00;
      d2_q     <= 8'h00;
      done_q   <= 1'b0;
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      s_q      <= 1'b0;
`ifdef ALUSEQ_OVF_EN
      of_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      sub_q    <= sub_d;
      cy_q     <= cy_d;
      zacc_q   <= zacc_d;
      aluop_q  <= aluop_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      done_q   <= done_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      s_q      <= s_d;
`ifdef ALUSEQ_OVF_EN
      of_q     <= of_d;
`endif
    end
  end

  always_ff @(posedge i_CLK) begin
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
    r_q   <= r_d;
    c1_q  <= c1_d;
  end

  assign bus.o_Busy     = (state_q != ALUSEQ_ST_IDLE);
  assign bus.o_Done     = done_q;
  assign bus.o_Result   = result_q;
  assign bus.o_C        = c_q;
  assign bus.o_Z        = z_q;
  assign bus.o_S        = s_q;
`ifdef ALUSEQ_OVF_EN
  assign bus.o_OF       = of_q;
`endif
  assign bus.o_ALUOp    = aluop_q;
  assign bus.o_ALUData1 = d1_q;
  assign bus.o_ALUData2 = d2_q;

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// tb_alu_mp_sequencer
//   Directed bench for alu_mp_sequencer with a behavioural 8-bit ALU that
//   evaluates on negedge. Requests push their hand-computed response into a
//   scoreboard queue; a monitor pops and compares on every o_Done.
module tb_alu_mp_sequencer;
  import alu_mp_sequencer_pkg::*;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        c, z, s, of;
    int          lat;
    int          nfix;
    int          start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   fix_cnt = 0;
  exp_t sbq[$];

  alu_mp_sequencer_if #(.MAX_BYTES(4), .LW(3)) bus ();

  alu_mp_sequencer #(.MAX_BYTES(4), .LW(3)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural ALU: evaluates registered operands on negedge.
  initial begin
    bus.i_ALUResult = 8'h00;
    bus.i_ALUC      = 1'b0;
  end
  always @(negedge clk) begin
    logic [8:0] t;
    case (bus.o_ALUOp)
      ALUOP_ADD: begin t = {1'b0, bus.o_ALUData1} + {1'b0, bus.o_ALUData2};
                       bus.i_ALUResult = t[7:0]; bus.i_ALUC = t[8]; end
      ALUOP_SUB: begin bus.i_ALUResult = bus.o_ALUData1 - bus.o_ALUData2;
                       bus.i_ALUC = (bus.o_ALUData1 < bus.o_ALUData2); end
      ALUOP_INC: begin bus.i_ALUResult = bus.o_ALUData1 + 8'h01;
                       bus.i_ALUC = (bus.o_ALUData1 == 8'hFF); end
      ALUOP_DEC: begin bus.i_ALUResult = bus.o_ALUData1 - 8'h01;
                       bus.i_ALUC = (bus.o_ALUData1 == 8'h00); end
      default:   begin bus.i_ALUResult = bus.o_ALUData1; bus.i_ALUC = 1'b0; end
    endcase
  end

  task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s v%0d got=0x%0h exp=0x%0h", nm, id, got, exp);
    end
  endtask

  // Monitor: count fix-up ops and compare every completion.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      fix_cnt = 0;
    end else begin
      if (bus.o_ALUOp == ALUOP_INC || bus.o_ALUOp == ALUOP_DEC) fix_cnt++;
      if (bus.o_Done) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done got=1 exp=0 at cycle %0d", cyc);
        end else begin
          e = sbq.pop_front();
          chk("result",  e.id, bus.o_Result, e.res);
          chk("carry",   e.id, 32'(bus.o_C), 32'(e.c));
          chk("zero",    e.id, 32'(bus.o_Z), 32'(e.z));
          chk("sign",    e.id, 32'(bus.o_S), 32'(e.s));
`ifdef ALUSEQ_OVF_EN
          chk("ovf",     e.id, 32'(bus.o_OF), 32'(e.of));
`endif
          chk("busy_at_done", e.id, 32'(bus.o_Busy), 32'd0);
          chk("latency", e.id, 32'(cyc - e.start_cyc), 32'(e.lat));
          chk("fixups",  e.id, 32'(fix_cnt), 32'(e.nfix));
        end
        fix_cnt = 0;
      end
    end
  end

  task automatic issue(input int id, input logic sub, input logic [2:0] len,
                       input logic [31:0] a, input logic [31:0] b, input logic push,
                       input logic [31:0] res, input logic c, input logic z,
                       input logic s, input logic of, input int lat, input int nfix);
    exp_t e;
    @(negedge clk);
    bus.i_Sub   = sub;
    bus.i_Len   = len;
    bus.i_A     = a;
    bus.i_B     = b;
    bus.i_Start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_Start = 1'b0;
    if (push) begin
      e.id = id; e.res = res; e.c = c; e.z = z; e.s = s; e.of = of;
      e.lat = lat; e.nfix = nfix; e.start_cyc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_drain(input int id);
    int t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #2;
    if (sbq.size() != 0) begin
      checks++; failures++;
      $display("FAIL timeout v%0d got=no_done exp=done", id);
      sbq.delete();
    end
  endtask

  task automatic run(input int id, input logic sub, input logic [2:0] len,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                     input logic c, input logic z, input logic s, input logic of,
                     input int lat, input int nfix);
    issue(id, sub, len, a, b, 1'b1, res, c, z, s, of, lat, nfix);
    wait_drain(id);
  endtask

  task automatic chk_reset_state(input int id);
    chk("rst_result", id, bus.o_Result, 32'h0);
    chk("rst_flags",  id, {28'h0, bus.o_Busy, bus.o_Done, bus.o_C, bus.o_Z}, 32'h0);
    chk("rst_sign",   id, 32'(bus.o_S), 32'h0);
`ifdef ALUSEQ_OVF_EN
    chk("rst_ovf",    id, 32'(bus.o_OF), 32'h0);
`endif
    chk("rst_aluop",  id, 32'(bus.o_ALUOp), 32'(ALUOP_PD1));
    chk("rst_data",   id, {16'h0, bus.o_ALUData1, bus.o_ALUData2}, 32'h0);
  endtask

  initial begin
    int t;
    bus.i_Start = 1'b0;
    bus.i_Sub   = 1'b0;
    bus.i_Len   = 3'd0;
    bus.i_A     = 32'h0;
    bus.i_B     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state(0);
    @(negedge clk);
    rst = 1'b0;

    //  id sub len  A             B             result        C     Z     S     OF   lat nfix
    run(1, 0, 3'd2, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 7, 1);
    run(2, 1, 3'd1, 32'h0000_0000, 32'h0000_0001, 32'h0000_00FF, 1'b1, 1'b0, 1'b1, 1'b0, 3, 0);
    run(3, 0, 3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 15, 3);

    // Len=0 clamps to 4; a second start mid-run must be ignored.
    issue(4, 1, 3'd0, 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 9, 0);
    repeat (2) @(negedge clk);
    bus.i_Sub = 1'b0; bus.i_Len = 3'd1; bus.i_A = 32'h11; bus.i_B = 32'h22;
    bus.i_Start = 1'b1;
    @(negedge clk);
    bus.i_Start = 1'b0;
    wait_drain(4);
    repeat (12) @(posedge clk);

    run(5, 1, 3'd2, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0, 7, 1);
    run(6, 0, 3'd2, 32'h0000_8000, 32'h0000_8000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 5, 0);
    run(7, 0, 3'd1, 32'hAABB_CC10, 32'h1122_3305, 32'h0000_0015, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    run(8, 0, 3'd5, 32'h0100_0000, 32'h0100_0000, 32'h0200_0000, 1'b0, 1'b0, 1'b0, 1'b0, 9, 0);
    run(9, 0, 3'd3, 32'h007F_FFFF, 32'h0000_0001, 32'h0080_0000, 1'b0, 1'b0, 1'b1, 1'b1, 11, 2);

    // Reset during FIXW of a Len=3 ADD (INC visible on o_ALUOp marks FIXW).
    issue(10, 0, 3'd3, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (bus.o_ALUOp != ALUOP_INC && t < 50);
    checks++;
    if (bus.o_ALUOp != ALUOP_INC) begin
      failures++;
      $display("FAIL reach_fixw got=0x%0h exp=0x%0h", bus.o_ALUOp, ALUOP_INC);
    end
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state(10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run(11, 0, 3'd1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    run(12, 0, 3'd1, 32'h0000_007F, 32'h0000_0001, 32'h0000_0080, 1'b0, 1'b0, 1'b1, 1'b1, 3, 0);
    run(13, 1, 3'd1, 32'h0000_0080, 32'h0000_0001, 32'h0000_007F, 1'b0, 1'b0, 1'b0, 1'b1, 3, 0);

    repeat (5) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
